// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample feeder.
//   sample_t             : one IEEE-754 single-precision sample, carried as raw bits
//   feeder_state_t       : feeder stream state (ACCEPT -> DRAIN -> DONE)
//   FEEDER_DEPTH_DEFAULT : default FIFO depth
package fir_pkg;

    typedef logic [31:0] sample_t;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        DONE
    } feeder_state_t;

    localparam int unsigned FEEDER_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with show-ahead head output.
//   clk, rst      : clock, asynchronous active-low reset
//   i_clear       : synchronous flush
//   i_wr/i_wr_data: push (caller guarantees !o_full)
//   i_rd          : pop  (caller guarantees !o_empty)
//   o_head        : sample at the read pointer
//   o_full/o_empty/o_level : occupancy status
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      w_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (i_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign o_level = w_level;
    assign o_full  = (w_level == (AW+1)'(DEPTH));
    assign o_empty = (w_level == '0);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_sample_feeder.sv
// Upstream feeder for the FIR filter: buffers samples from a valid/ready source
// and answers each fir_next pulse with the next sample on fir_in.
//   clk, rst                        : clock, asynchronous active-low reset
//   clear                           : synchronous flush (fir_in is kept)
//   s_data/s_valid/s_last/s_ready   : source stream
//   fir_next/fir_in/fir_stop        : FIR request, sample and end-of-stream
//   underrun/level/sent             : debug status
// DEPTH must be a power of two, at least 2.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = FEEDER_DEPTH_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   fir_next,
    output logic [WIDTH-1:0]       fir_in,
    output logic                   fir_stop,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       sent
);

    feeder_state_t    r_state;
    feeder_state_t    w_state_d;
    logic             r_alive;     // holds s_ready low until the first edge after reset
    logic [WIDTH-1:0] r_fir_in;
    logic             r_underrun;
    logic [CNT_W-1:0] r_sent;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic             w_wr;
    logic             w_pop;
    logic             w_underrun_set;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (clear),
        .i_wr      (w_wr),
        .i_wr_data (s_data),
        .i_rd      (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ACCEPT;
        else      r_state <= w_state_d;
    end

    always_comb begin
        w_state_d      = r_state;
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;
        s_ready        = !w_full && (r_state == ACCEPT) && !clear && r_alive;
        w_wr           = s_valid && s_ready;

        // Requests are ignored once the stream is done.
        if (fir_next && (r_state != DONE) && !clear) begin
            if (!w_empty)                w_pop          = 1'b1;
            else if (r_state == ACCEPT)  w_underrun_set = 1'b1;
            else                         w_state_d      = DONE;
        end

        if (w_wr && s_last) w_state_d = DRAIN;
        if (clear)          w_state_d = ACCEPT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive    <= 1'b0;
            r_fir_in   <= '0;
            r_underrun <= 1'b0;
            r_sent     <= '0;
        end else begin
            r_alive <= 1'b1;
            if (clear) begin
                r_underrun <= 1'b0;
                r_sent     <= '0;
            end else begin
                if (w_pop) begin
                    r_fir_in <= w_head;
                    if (r_sent != {CNT_W{1'b1}}) r_sent <= r_sent + 1'b1;
                end
                if (w_underrun_set) r_underrun <= 1'b1;
            end
        end
    end

    assign fir_in   = r_fir_in;
    assign fir_stop = (r_state == DONE);
    assign underrun = r_underrun;
    assign sent     = r_sent;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: a queue-based reference model
// predicts each request's outcome into a scoreboard; a monitor compares the
// DUT response the cycle after every fir_next pulse.
module tb_fir_sample_feeder;
    import fir_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        fir_next = 1'b0;
    logic [31:0] fir_in;
    logic        fir_stop;
    logic        underrun;
    logic [4:0]  level;
    logic [15:0] sent;

    always #5 clk = ~clk;

    fir_sample_feeder #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .fir_next (fir_next),
        .fir_in   (fir_in),
        .fir_stop (fir_stop),
        .underrun (underrun),
        .level    (level),
        .sent     (sent)
    );

    typedef struct {
        logic [31:0] fir_in;
        logic        stop;
        logic        underrun;
        logic [15:0] sent;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: stream contents and flags.
    sample_t     m_q[$];
    bit          m_last;
    bit          m_stop;
    bit          m_underrun;
    bit          m_alive;
    logic [31:0] m_fir_in;
    int unsigned m_sent;

    int errors = 0;
    int checks = 0;
    bit acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset(input bit keep_fir_in);
        m_q.delete();
        m_last     = 0;
        m_stop     = 0;
        m_underrun = 0;
        m_sent     = 0;
        if (!keep_fir_in) m_fir_in = '0;
    endtask

    // One clock of stimulus; the model advances in step with the DUT edge.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit n,
                        input bit c, output bit accepted);
        bit   ready;
        exp_t e;
        @(negedge clk);
        s_valid  = v;
        s_data   = d;
        s_last   = l;
        fir_next = n;
        clear    = c;
        #1;
        ready = (m_q.size() < DEPTH) && !m_last && !m_stop && !c && m_alive;
        check("s_ready", {31'b0, s_ready}, {31'b0, ready});
        check("level", {27'b0, level}, m_q.size());
        accepted = v && ready;
        if (c) begin
            model_reset(1);
        end else begin
            if (n && !m_stop) begin
                if (m_q.size() > 0) begin
                    m_fir_in = m_q.pop_front();
                    if (m_sent < (1 << CNT_W) - 1) m_sent++;
                end else if (!m_last) begin
                    m_underrun = 1;
                end else begin
                    m_stop = 1;
                end
            end
            if (accepted) begin
                m_q.push_back(d);
                if (l) m_last = 1;
            end
        end
        if (n) begin
            e.fir_in   = m_fir_in;
            e.stop     = m_stop;
            e.underrun = m_underrun;
            e.sent     = 16'(m_sent);
            exp_q.push_back(e);
        end
        m_alive = 1;
    endtask

    task automatic idle(input int cycles);
        bit a;
        for (int i = 0; i < cycles; i++) step(0, '0, 0, 0, 0, a);
    endtask

    task automatic flush();
        bit a;
        step(0, '0, 0, 0, 1, a);
    endtask

    // Monitor: every request is answered on the following cycle.
    always @(posedge clk) begin : monitor
        exp_t e;
        if (rst && fir_next) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: request with no expected response at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("fir_in", fir_in, e.fir_in);
                check("fir_stop", {31'b0, fir_stop}, {31'b0, e.stop});
                check("underrun", {31'b0, underrun}, {31'b0, e.underrun});
                check("sent", {16'b0, sent}, {16'b0, e.sent});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fir_in"}, fir_in, 32'h0);
        check({tag, "_fir_stop"}, {31'b0, fir_stop}, 32'h0);
        check({tag, "_underrun"}, {31'b0, underrun}, 32'h0);
        check({tag, "_level"}, {27'b0, level}, 32'h0);
        check({tag, "_sent"}, {16'b0, sent}, 32'h0);
        check({tag, "_s_ready"}, {31'b0, s_ready}, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s_ready_before_first_edge", {31'b0, s_ready}, 32'h0);
        @(posedge clk);
        m_alive = 1;
    endtask

    initial begin
        int idx;
        int budget;
        logic [31:0] nan_val;

        model_reset(0);
        m_alive = 0;
        #12;
        check_reset_outputs("por");
        release_reset();

        // Three preloaded samples, last on the third, read out 4 cycles apart.
        step(1, 32'h3F800000, 0, 0, 0, acc);
        step(1, 32'h40000000, 0, 0, 0, acc);
        step(1, 32'hC0400000, 1, 0, 0, acc);
        for (int k = 0; k < 3; k++) begin
            step(0, '0, 0, 1, 0, acc);
            idle(3);
        end
        check("three_sent", {16'b0, sent}, 32'd3);
        check("no_stop_yet", {31'b0, fir_stop}, 32'h0);
        step(0, '0, 0, 1, 0, acc);
        idle(1);
        check("stop_after_drain", {31'b0, fir_stop}, 32'h1);
        step(0, '0, 0, 1, 0, acc);   // request after stop: no effect
        idle(1);
        flush();

        // Fill to full; 17th write refused, even alongside a read.
        for (int k = 0; k < DEPTH; k++) step(1, $urandom, 0, 0, 0, acc);
        step(1, 32'hDEADBEEF, 0, 0, 0, acc);
        check("full_refuses", {31'b0, acc}, 32'h0);
        step(1, 32'hDEADBEEF, 0, 1, 0, acc);
        check("full_refuses_with_read", {31'b0, acc}, 32'h0);
        idle(1);
        check("level_after_pop", {27'b0, level}, 32'd15);
        flush();

        // Wrap-around with random interleaving of writes and reads.
        idx = 1;
        budget = 0;
        while ((idx <= 40 || m_q.size() > 0) && budget < 2000) begin
            step((idx <= 40) && ($urandom_range(0, 3) != 0), idx, 0,
                 ($urandom_range(0, 2) == 0) && (m_q.size() > 0), 0, acc);
            if (acc) idx++;
            budget++;
        end
        idle(1);
        check("wrap_sent", {16'b0, sent}, 32'd40);
        check("wrap_no_underrun", {31'b0, underrun}, 32'h0);
        check("wrap_last_sample", fir_in, 32'd40);
        flush();

        // Underrun on an empty FIFO, then normal delivery.
        step(0, '0, 0, 1, 0, acc);
        step(1, 32'h7F800000, 0, 0, 0, acc);
        step(0, '0, 0, 1, 0, acc);
        idle(1);
        check("underrun_sticky", {31'b0, underrun}, 32'h1);
        flush();

        // Simultaneous write and read at level 5.
        for (int k = 0; k < 5; k++) step(1, $urandom, 0, 0, 0, acc);
        step(1, 32'hFF800001, 0, 1, 0, acc);
        idle(1);
        check("level_hold_5", {27'b0, level}, 32'd5);
        flush();

        // Asynchronous reset between edges with data buffered.
        for (int k = 0; k < 7; k++) step(1, $urandom, 0, 0, 0, acc);
        idle(1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset(0);
        m_alive = 0;
        release_reset();
        nan_val = 32'h7FC00000;
        step(1, nan_val, 0, 0, 0, acc);
        step(0, '0, 0, 1, 0, acc);
        idle(2);
        check("nan_bit_exact", fir_in, nan_val);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Upstream stage of the FIR filter. Buffers 32-bit IEEE-754 single-precision samples from a valid/ready source.
- Answers each one-cycle `next` request from the FIR with the following sample on the FIR `in` bus.
- Asserts the FIR `stop` input once the source has signalled end-of-stream and the buffer has drained.
- Reports underrun and sample counts for debug and testbench checks.

Parameters:
- WIDTH, 32: sample width in bits (IEEE single).
- DEPTH, 16: FIFO entries; must be a power of 2, at least 2.
- CNT_W, 16: width of the sent-sample counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- clear  in  1  synchronous flush, active-high.
- s_data  in  WIDTH  source sample.
- s_valid  in  1  source sample valid.
- s_last  in  1  qualifies s_data as the final sample of the stream (sampled with s_valid).
- s_ready  out  1  feeder accepts s_data this cycle.
- fir_next  in  1  FIR requests the next sample (one-cycle pulse).
- fir_in  out  WIDTH  sample driven to FIR `in`.
- fir_stop  out  1  to FIR `stop`; end of stream, sticky.
- underrun  out  1  sticky: a request arrived with an empty FIFO before end-of-stream.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sent  out  CNT_W  samples delivered to the FIR.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to ACCEPT.
  - Pointers, level and sent are 0.
  - fir_in is 0; fir_stop and underrun are 0.
  - s_ready is 0 while rst=0 and becomes 1 on the first clock after release.
- Reset asserted mid-stream drops all buffered data. No output glitches on release beyond the listed reset values.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo DEPTH.
  - full = level==DEPTH; empty = level==0.
- Write and last_seen:
  - A write occurs on a cycle where s_valid && s_ready.
  - s_ready = !full && state==ACCEPT && !clear. s_ready is not raised by a same-cycle read; a full FIFO refuses the write even if a read occurs.
  - A write with s_last=1 stores the sample and sets last_seen.
- Read on fir_next=1:
  - If !empty: pop the head. fir_in updates to the popped sample on the same clock edge, so it is valid from the cycle after the request. Increment sent (saturating at all-ones).
  - If empty and !last_seen: no pop. fir_in holds its previous value, underrun sets, sent unchanged.
  - If empty and last_seen: fir_stop sets and state goes to DONE.
  - fir_next with fir_stop already high has no effect.
- A simultaneous write and read updates both pointers; level is unchanged.
- fir_in holds its last value between requests.
- States:
  - ACCEPT: writes allowed. Goes to DRAIN when a write carries s_last.
  - DRAIN: no writes. Goes to DONE on a request with the FIFO empty.
  - DONE: fir_stop=1, writes blocked. Leaves only via clear or reset.
- A request while in ACCEPT with the FIFO empty is an underrun. It does not stop the stream.
- clear=1 (synchronous): same effect as reset on the next edge, except that fir_in holds its value. clear has priority over a write or read in the same cycle.
- No arithmetic on sample data; samples pass bit-exact, including NaN/Inf payloads.

Decomposition:
- Package fir_pkg:
  - typedef sample_t = logic [31:0].
  - enum feeder_state_t {ACCEPT, DRAIN, DONE}.
  - Constant FEEDER_DEPTH_DEFAULT = 16.
- One sub-module, sync_fifo: storage, pointers, level, full/empty.
- The feeder top keeps the state machine, request handling, flags and counters.

Test Plan:
- Preload 0x3F800000, 0x40000000, 0xC0400000 (last on the third), then three fir_next pulses 4 cycles apart: fir_in is 1.0, 2.0, -3.0, each valid the cycle after its request; sent=3; fir_stop=0. A fourth pulse sets fir_stop=1 the next cycle and state=DONE.
- Write 16 samples with no reads: level=16, s_ready=0, and a 17th s_valid is not accepted. One fir_next then drops level to 15 and s_ready returns to 1 the following cycle.
- Wrap-around: stream 40 samples 0x00000001..0x00000028 with interleaved reads, level never above 16: fir_in order matches exactly, sent=40, no underrun.
- Empty FIFO, no s_last, fir_next pulse: underrun=1, fir_in unchanged, sent=0, fir_stop=0. A later write followed by fir_next delivers normally; underrun stays 1.
- Simultaneous write and read at level=5: level stays 5, and the head sample goes out on fir_in.
- Assert rst=0 asynchronously between clock edges with level=7 and fir_stop=0: all outputs reach their reset values immediately. After release, a write of 0x7FC00000 then fir_next gives fir_in=0x7FC00000 (NaN bit-exact).
